ifd_prefetch_queue: RTL
=======================

Name: ifd_prefetch_queue

Overview:
- Instruction prefetch stage directly upstream of the instruction decoder.
- Issues sequential word reads to program memory, starting at the program base address, and buffers returned words with their addresses in a small FIFO.
- Presents the FIFO head to the decoder through a valid/ready handshake. The decoder's stall is the inverse of ready.
- Flushes and refetches on control-flow redirects from the execution unit (JMP, JMS, taken skips).

Parameters:
- ADDR_WIDTH, 12, memory address width (PDP-8 word address).
- DATA_WIDTH, 12, instruction word width.
- DEPTH, 4, FIFO entries. Power of two, ≥2.

Ports:
- clk  in  1  free-running clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begin fetching at base_addr
- base_addr  in  ADDR_WIDTH  first fetch address (normally 12'o200)
- halt  in  1  level; suppress new memory requests (HLT executed)
- redirect  in  1  one-cycle pulse; flush and refetch from redirect_addr
- redirect_addr  in  ADDR_WIDTH  new fetch address
- mem_rd_req  out  1  read request to memory
- mem_rd_addr  out  ADDR_WIDTH  read address; stable while mem_rd_req high
- mem_rd_ack  in  1  memory completes the current read this cycle
- mem_rd_data  in  DATA_WIDTH  read data, valid with mem_rd_ack
- instr_valid  out  1  FIFO head valid
- instr_data  out  DATA_WIDTH  FIFO head word
- instr_addr  out  ADDR_WIDTH  address of the FIFO head word
- instr_ready  in  1  decoder accepts the head this cycle (not stalled)
- count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset
  - All outputs are 0. FIFO is empty. State is IDLE. The fetch address register is 0.
  - Reset overrides every other input, including an outstanding request. A mem_rd_ack arriving after reset is ignored.
- States
  - IDLE: mem_rd_req=0. start moves to RUN and loads fetch_addr=base_addr. redirect is ignored in IDLE.
  - RUN: assert mem_rd_req with mem_rd_addr=fetch_addr when halt=0 and (count + outstanding) < DEPTH.
    - The request is held with a stable address until mem_rd_ack. Ack may come in the same cycle the request is raised.
    - On ack: push {mem_rd_addr, mem_rd_data} and set fetch_addr = fetch_addr+1, wrapping modulo 2^ADDR_WIDTH (7777→0000 octal).
    - The next request may be issued in the cycle after ack (back-to-back allowed).
  - DRAIN: entered from RUN when redirect arrives while a request is outstanding and mem_rd_ack=0 that cycle.
    - Hold mem_rd_req and the old address until ack, then discard the data.
    - Next cycle return to RUN, fetching from the latched redirect_addr.
- Redirect
  - Same cycle: FIFO is cleared (instr_valid=0, count=0 next cycle) and fetch_addr<=redirect_addr.
  - If mem_rd_ack coincides with redirect, that data is discarded and the state stays RUN.
  - Redirect has priority over push and pop in the same cycle.
  - A second redirect during DRAIN replaces the latched address.
- Halt
  - Does not flush and does not abort an outstanding request; that data is pushed normally.
  - Pops continue while halt is high. Fetching resumes from fetch_addr when halt falls.
- FIFO
  - Pop occurs when instr_valid & instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Credit rule (count + outstanding < DEPTH) means a push never occurs when full. An overflow is a design error; flag it with an assertion.
  - Empty: instr_valid=0, and instr_data/instr_addr hold their last values.
- Latency
  - Data acked in cycle N is visible at the head in cycle N+1 if the FIFO was empty.
  - Head outputs and count are registered.
- Outstanding requests: at most one in flight at any time.

Test Plan:
- Fill: reset, start with base_addr=12'o200, instr_ready=0, memory acks 1 cycle after req.
  - Requests go to 0200, 0201, 0202, 0203, then mem_rd_req=0.
  - count=4; instr_valid=1, instr_addr=0200, instr_data=mem[0200].
- Stream: instr_ready=1 with a zero-wait memory (ack in the same cycle as req).
  - After a 1-cycle fill latency, one pop per cycle.
  - instr_addr sequence is 0200, 0201, 0202, … with no gaps.
- Redirect during outstanding read: req at 0205 pending, redirect to 0300, ack 3 cycles later with data 7402.
  - 7402 is never presented and count=0.
  - Next mem_rd_addr=0300; first instr_addr=0300.
- Coincident redirect and ack: ack at 0204 in the same cycle as redirect to 0010.
  - Data is dropped; next request is 0010 one cycle later; FIFO is empty.
- Wrap and halt: base_addr=7776, ack latency 1.
  - Addresses are 7776, 7777, 0000.
  - halt raised with count=2 and one read outstanding: that read is pushed (count=3), then no req until halt falls; the next address is 0001.
- Reset mid-operation: reset while req high and count=3.
  - Next cycle mem_rd_req=0, instr_valid=0, count=0, state IDLE.
  - A late ack is ignored. start with 0200 restarts cleanly.

Source files
------------

// File: rtl/ifd_prefetch_queue.sv
// ---------------------------------------------------------------------------
// ifd_prefetch_queue
//
// Instruction prefetch stage sitting directly in front of the decoder.
// Issues sequential single-word reads to program memory, buffers returned
// words together with their addresses in a small FIFO, and presents the FIFO
// head to the decoder over a valid/ready handshake. Control-flow redirects
// from the execution unit flush the queue and restart fetching at a new
// address; a read that is still in flight when the redirect arrives is
// allowed to complete and its data is thrown away (DRAIN state).
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start, base_addr  one-cycle pulse to begin fetching at base_addr
//   halt              level; no new memory requests while high
//   redirect,
//   redirect_addr     one-cycle pulse; flush and refetch from redirect_addr
//   mem_rd_req/addr   read request to program memory (address held until ack)
//   mem_rd_ack/data   memory completes the current read, data valid with ack
//   instr_valid/data/
//   instr_addr        registered FIFO head presented to the decoder
//   instr_ready       decoder accepts the head this cycle
//   count             registered FIFO occupancy
// ---------------------------------------------------------------------------

module ifd_prefetch_queue_chk #(
    parameter int CNT_W = 3,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    input logic             push,
    input logic [CNT_W-1:0] count
);
    // The request credit rule must never let a returned word land in a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && (count == CNT_W'(DEPTH))));
endmodule

module ifd_prefetch_queue #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic                       halt,
    input  logic                       redirect,
    input  logic [ADDR_WIDTH-1:0]      redirect_addr,
    output logic                       mem_rd_req,
    output logic [ADDR_WIDTH-1:0]      mem_rd_addr,
    input  logic                       mem_rd_ack,
    input  logic [DATA_WIDTH-1:0]      mem_rd_data,
    output logic                       instr_valid,
    output logic [DATA_WIDTH-1:0]      instr_data,
    output logic [ADDR_WIDTH-1:0]      instr_addr,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] fetch_addr_r, fetch_addr_s;
    logic                  req_r, req_s;
    logic [ADDR_WIDTH-1:0] rd_addr_r, rd_addr_s;
    logic [PTR_W-1:0]      wr_ptr_r, wr_ptr_s;
    logic [PTR_W-1:0]      rd_ptr_r, rd_ptr_s;
    logic [CNT_W-1:0]      count_r, count_s;
    logic                  valid_r;
    logic [DATA_WIDTH-1:0] head_data_r, head_data_s;
    logic [ADDR_WIDTH-1:0] head_addr_r, head_addr_s;
    logic [ADDR_WIDTH-1:0] addr_mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
    logic                  ack_s, push_s, pop_s, flush_s, outstanding_s;

    // Queue-level events: accepted read data, decoder pop and redirect flush.
    always_comb begin
        ack_s         = req_r & mem_rd_ack;
        outstanding_s = req_r & ~mem_rd_ack;
        pop_s         = valid_r & instr_ready;
        push_s        = 1'b0;
        flush_s       = 1'b0;
        case (state_r)
            RUN: begin
                // Redirect wins over a coincident ack: that word is stale.
                if (redirect) begin
                    flush_s = 1'b1;
                end else begin
                    push_s = ack_s;
                end
            end
            DRAIN: begin
                // Queue is already empty here; the drained word is never pushed.
                flush_s = redirect;
            end
            default: begin
                push_s  = 1'b0;
                flush_s = 1'b0;
            end
        endcase
    end

    // Next pointers and occupancy; a flush overrides push and pop.
    always_comb begin
        if (flush_s) begin
            wr_ptr_s = {PTR_W{1'b0}};
            rd_ptr_s = {PTR_W{1'b0}};
            count_s  = {CNT_W{1'b0}};
        end else begin
            wr_ptr_s = wr_ptr_r + PTR_W'(push_s);
            rd_ptr_s = rd_ptr_r + PTR_W'(pop_s);
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + CNT_W'(1);
                2'b01:   count_s = count_r - CNT_W'(1);
                default: count_s = count_r;
            endcase
        end
    end

    // Next head word; when the word being written becomes the head it bypasses storage.
    always_comb begin
        if (push_s && (wr_ptr_r == rd_ptr_s)) begin
            head_addr_s = rd_addr_r;
            head_data_s = mem_rd_data;
        end else begin
            head_addr_s = addr_mem_r[rd_ptr_s];
            head_data_s = data_mem_r[rd_ptr_s];
        end
    end

    // Fetch sequencer: request issue, address advance, redirect and drain handling.
    always_comb begin
        state_s      = state_r;
        fetch_addr_s = fetch_addr_r;
        req_s        = req_r;
        rd_addr_s    = rd_addr_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s      = RUN;
                    fetch_addr_s = base_addr;
                    req_s        = ~halt;
                    rd_addr_s    = base_addr;
                end else begin
                    req_s = 1'b0;
                end
            end
            RUN: begin
                if (redirect) begin
                    fetch_addr_s = redirect_addr;
                    if (outstanding_s) begin
                        // Keep the old request on the bus until memory finishes it.
                        state_s = DRAIN;
                    end else begin
                        req_s     = ~halt;
                        rd_addr_s = redirect_addr;
                    end
                end else begin
                    if (ack_s) begin
                        fetch_addr_s = fetch_addr_r + ADDR_WIDTH'(1);
                    end else begin
                        fetch_addr_s = fetch_addr_r;
                    end
                    // One read in flight at most; count_s already includes this
                    // cycle's push/pop, so the credit check covers the new request.
                    if (!outstanding_s) begin
                        req_s     = ~halt && (count_s < CNT_W'(DEPTH));
                        rd_addr_s = fetch_addr_s;
                    end else begin
                        req_s     = 1'b1;
                        rd_addr_s = rd_addr_r;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_addr_s = redirect_addr;
                end else begin
                    fetch_addr_s = fetch_addr_r;
                end
                if (ack_s) begin
                    req_s   = 1'b0;
                    state_s = RUN;
                end else begin
                    req_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
            end
        endcase
    end

    // Control, pointer and registered-output state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            fetch_addr_r <= {ADDR_WIDTH{1'b0}};
            req_r        <= 1'b0;
            rd_addr_r    <= {ADDR_WIDTH{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            valid_r      <= 1'b0;
            head_data_r  <= {DATA_WIDTH{1'b0}};
            head_addr_r  <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r      <= state_s;
            fetch_addr_r <= fetch_addr_s;
            req_r        <= req_s;
            rd_addr_r    <= rd_addr_s;
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            count_r      <= count_s;
            valid_r      <= (count_s != CNT_W'(0));
            // An empty queue keeps showing the last head word.
            if (count_s != CNT_W'(0)) begin
                head_data_r <= head_data_s;
                head_addr_r <= head_addr_s;
            end
        end
    end

    // Queue storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            addr_mem_r[wr_ptr_r] <= rd_addr_r;
            data_mem_r[wr_ptr_r] <= mem_rd_data;
        end
    end

    assign mem_rd_req  = req_r;
    assign mem_rd_addr = rd_addr_r;
    assign instr_valid = valid_r;
    assign instr_data  = head_data_r;
    assign instr_addr  = head_addr_r;
    assign count       = count_r;

    ifd_prefetch_queue_chk #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .count (count_r)
    );
endmodule
